// File: rtl/uart_rx_frame_ctrl.sv
// UART receiver frame controller on a x4-oversample baud clock with a 4-phase output handshake.
// Define UART_RX_FRAME_CTRL_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_frame_ctrl (
  input  logic       b_bd_clock,
  input  logic       inRESET,
  input  logic       iEN,
  input  logic       iRXD,
  input  logic       iPARITY_ODD,
  input  logic       iACK,
  output logic       oREQ,
  output logic [7:0] oDATA,
  output logic       oFERR,
  output logic       oPERR,
  output logic       oOVERRUN,
  output logic       oBREAK
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
    PARITY     = 3'd3,
`endif
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] buf_q, buf_d;
  logic       req_q, req_d;
  logic [7:0] data_q, data_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       brk_q, brk_d;
  logic       deliver, dlv_ferr;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
  logic       perr_q, perr_d;
  logic       operr_q, operr_d;
`else
  logic       unused_parity_odd;
  assign unused_parity_odd = iPARITY_ODD;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 2'd1;
    bit_d    = bit_q;
    buf_d    = buf_q;
    brk_d    = brk_q;
    deliver  = 1'b0;
    dlv_ferr = 1'b0;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (iEN && !iRXD) begin
          state_d = START;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == 2'd1 && iRXD) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q == 2'd3) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q == 2'd1) buf_d = {iRXD, buf_q[7:1]};
        if (cnt_q == 2'd3) begin
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
      PARITY: begin
        if (cnt_q == 2'd1) perr_d = ((^buf_q) ^ iRXD) != iPARITY_ODD;
        if (cnt_q == 2'd3) state_d = STOP;
      end
`endif
      STOP: begin
        if (cnt_q == 2'd1) begin
          cnt_d = 2'd0;
          // An all-zero byte with a low stop bit is a break, not a framing error
          if (!iRXD && buf_q == 8'h00) begin
            state_d = BREAK_WAIT;
            brk_d   = 1'b1;
          end else begin
            state_d  = IDLE;
            deliver  = 1'b1;
            dlv_ferr = !iRXD;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = 2'd0;
        if (iRXD) begin
          state_d = IDLE;
          brk_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (!iEN && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      brk_d   = 1'b0;
      deliver = 1'b0;
    end
  end

  // Handshake side runs independently of the receive FSM; an ack and a dropped frame may coincide
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
    operr_d = operr_q;
`endif
    if (req_q && iACK) req_d = 1'b0;
    if (deliver) begin
      if (req_q || iACK) begin
        ovr_d = 1'b1;
      end else begin
        req_d  = 1'b1;
        data_d = buf_q;
        ferr_d = dlv_ferr;
        ovr_d  = 1'b0;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
        operr_d = perr_q;
`endif
      end
    end
  end

  always_ff @(posedge b_bd_clock or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      bit_q   <= 3'd0;
      buf_q   <= 8'h00;
      req_q   <= 1'b0;
      data_q  <= 8'h00;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
      perr_q  <= 1'b0;
      operr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
      perr_q  <= perr_d;
      operr_q <= operr_d;
`endif
    end
  end

  assign oREQ     = req_q;
  assign oDATA    = data_q;
  assign oFERR    = ferr_q;
  assign oOVERRUN = ovr_q;
  assign oBREAK   = brk_q;
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
  assign oPERR    = operr_q;
`else
  assign oPERR    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected frames, a monitor checks each oREQ rise.
module tb_uart_rx_frame_ctrl;

  logic       b_bd_clock = 1'b0;
  logic       inRESET, iEN, iRXD, iPARITY_ODD, iACK;
  logic       oREQ, oFERR, oPERR, oOVERRUN, oBREAK;
  logic [7:0] oDATA;

  uart_rx_frame_ctrl dut (
    .b_bd_clock(b_bd_clock), .inRESET(inRESET), .iEN(iEN), .iRXD(iRXD),
    .iPARITY_ODD(iPARITY_ODD), .iACK(iACK), .oREQ(oREQ), .oDATA(oDATA),
    .oFERR(oFERR), .oPERR(oPERR), .oOVERRUN(oOVERRUN), .oBREAK(oBREAK)
  );

  always #5 b_bd_clock = ~b_bd_clock;

`ifdef UART_RX_FRAME_CTRL_PARITY_EN
  localparam int LAT = 42;
`else
  localparam int LAT = 38;
`endif

  typedef struct {
    logic [7:0] d;
    logic       ferr;
    logic       perr;
    logic       ovr;
    int         start;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_req = 1'b0;

  always @(posedge b_bd_clock) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endfunction

  // Monitor: every oREQ rise must match the oldest expected frame
  always @(negedge b_bd_clock) begin
    if (oREQ && !prev_req) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("data", oDATA, e.d);
        chk("ferr", oFERR, e.ferr);
        chk("perr", oPERR, e.perr);
        chk("overrun", oOVERRUN, e.ovr);
        chk("latency", cyc - e.start, LAT);
      end
    end
    prev_req = oREQ;
  end

  task automatic idle(input int n);
    iRXD = 1'b1;
    repeat (n) @(negedge b_bd_clock);
  endtask

  task automatic drive(input logic b);
    iRXD = b;
    repeat (4) @(negedge b_bd_clock);
  endtask

  // Sends start, 8 data bits LSB first, optional parity, stop; leaves the line at the stop level
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit dlv, input logic eferr, input logic eperr, input logic eovr);
    exp_t x;
    if (dlv) begin
      x.d = d; x.ferr = eferr; x.perr = eperr; x.ovr = eovr; x.start = cyc + 1;
      sb.push_back(x);
    end
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
`ifdef UART_RX_FRAME_CTRL_PARITY_EN
    drive(par);
`else
    if (par) begin end
`endif
    drive(stp);
  endtask

  task automatic ack();
    int n = 0;
    iACK = 1'b1;
    @(negedge b_bd_clock);
    while (oREQ && n < 10) begin
      @(negedge b_bd_clock);
      n++;
    end
    chk("ack_drop", oREQ, 0);
    iACK = 1'b0;
    @(negedge b_bd_clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    inRESET = 1'b0; iEN = 1'b1; iRXD = 1'b1; iPARITY_ODD = 1'b0; iACK = 1'b0;
    #3;
    chk("rst_req", oREQ, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_ferr", oFERR, 0);
    chk("rst_perr", oPERR, 0);
    chk("rst_ovr", oOVERRUN, 0);
    chk("rst_brk", oBREAK, 0);
    @(negedge b_bd_clock);
    @(negedge b_bd_clock);
    inRESET = 1'b1;
    idle(4);

    // Clean frame
    send_frame(8'hA5, ^8'hA5, 1'b1, 1, 0, 0, 0);
    idle(4);
    ack();

    // False start: one low edge only
    iRXD = 1'b0;
    @(negedge b_bd_clock);
    idle(10);
    chk("false_req", oREQ, 0);
    chk("false_brk", oBREAK, 0);
    chk("false_ferr", oFERR, 0);

    // Framing error
    send_frame(8'h3C, ^8'h3C, 1'b0, 1, 1, 0, 0);
    idle(6);
    ack();

    // Break: zero byte, low stop, line held low another 20 edges
    send_frame(8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (20) @(negedge b_bd_clock);
    chk("break_on", oBREAK, 1);
    chk("break_noreq", oREQ, 0);
    idle(3);
    chk("break_off", oBREAK, 0);
    idle(3);

    // Overrun: second frame dropped while first is unacknowledged
    send_frame(8'h11, ^8'h11, 1'b1, 1, 0, 0, 0);
    idle(4);
    send_frame(8'h22, ^8'h22, 1'b1, 0, 0, 0, 0);
    idle(4);
    chk("ovr_data", oDATA, 8'h11);
    chk("ovr_flag", oOVERRUN, 1);
    chk("ovr_req", oREQ, 1);
    ack();
    send_frame(8'h33, ^8'h33, 1'b1, 1, 0, 0, 0);
    idle(4);
    ack();

`ifdef UART_RX_FRAME_CTRL_PARITY_EN
    iPARITY_ODD = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1, 0, 0, 0);
    idle(4);
    ack();
    send_frame(8'h07, 1'b0, 1'b1, 1, 0, 1, 0);
    idle(4);
    ack();
`endif

    // Leave a frame pending, then reset mid-way through 8'hFF
    send_frame(8'hC3, ^8'hC3, 1'b1, 1, 0, 0, 0);
    idle(4);
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    iRXD = 1'b1;
    @(negedge b_bd_clock);
    #2;
    inRESET = 1'b0;
    #1;
    chk("mid_rst_req", oREQ, 0);
    chk("mid_rst_data", oDATA, 0);
    chk("mid_rst_ferr", oFERR, 0);
    chk("mid_rst_perr", oPERR, 0);
    chk("mid_rst_ovr", oOVERRUN, 0);
    chk("mid_rst_brk", oBREAK, 0);
    @(negedge b_bd_clock);
    inRESET = 1'b1;
    idle(30);
    chk("post_rst_req", oREQ, 0);
    send_frame(8'h5A, ^8'h5A, 1'b1, 1, 0, 0, 0);
    idle(4);
    ack();

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge b_bd_clock);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
